// File: rtl/charram_dram_ctrl.sv
// Two-port access sequencer for the 16k x4 character DRAM: arbitrates video
// fetches against CPU accesses and drives the multiplexed address and strobes.
module charram_dram_ctrl #(
    parameter int unsigned TRP         = 1,
    parameter int unsigned MAX_VID_RUN = 3
) (
    input  logic        i_MCLK,
    input  logic        i_RST_n,
    input  logic        i_VID_REQ,
    input  logic [13:0] i_VID_ADDR,
    output logic [3:0]  o_VID_DATA,
    output logic        o_VID_VALID,
    output logic        o_VID_MISS,
    input  logic        i_CPU_REQ,
    input  logic        i_CPU_WR,
    input  logic [13:0] i_CPU_ADDR,
    input  logic [3:0]  i_CPU_DIN,
    output logic [3:0]  o_CPU_DOUT,
    output logic        o_CPU_ACK,
    output logic [7:0]  o_RAM_ADDR,
    output logic [3:0]  o_RAM_DIN,
    input  logic [3:0]  i_RAM_DOUT,
    output logic        o_RAS_n,
    output logic        o_CAS_n,
    output logic        o_WR_n,
    output logic        o_RD_n
);
    localparam int unsigned AW  = 14;
    localparam int unsigned DW  = 4;
    localparam int unsigned RW  = 8;
    localparam int unsigned PCW = $clog2(TRP + 1);

    typedef enum logic [2:0] {S_IDLE, S_ROW, S_COL, S_ACC, S_PRE} state_t;

    state_t          r_state;
    logic [PCW-1:0]  r_pre_cnt;
    logic            r_vid_pend;
    logic [AW-1:0]   r_vid_addr;
    logic            r_cpu_req;
    logic            r_cpu_busy;
    logic [1:0]      r_vid_run;
    logic            r_cur_cpu;
    logic            r_cur_wr;
    logic [AW-1:0]   r_cur_addr;
    logic [DW-1:0]   r_cur_din;
    logic [RW-1:0]   r_ram_addr;
    logic [DW-1:0]   r_ram_din;
    logic [DW-1:0]   r_vid_data;
    logic [DW-1:0]   r_cpu_dout;
    logic            r_vid_valid;
    logic            r_vid_miss;
    logic            r_cpu_ack;
    logic            r_ras_n;
    logic            r_cas_n;
    logic            r_wr_n;
    logic            r_rd_n;

    logic            w_last_pre;
    logic            w_arb;
    logic            w_cpu_elig;
    logic            w_cpu_first;
    logic            w_vid_gnt;
    logic            w_cpu_gnt;
    logic [AW-1:0]   w_gnt_addr;

    // Arbitration: video wins unless the CPU has waited out MAX_VID_RUN video grants
    assign w_last_pre  = (r_state == S_PRE) && (r_pre_cnt == PCW'(TRP - 1));
    assign w_arb       = (r_state == S_IDLE) || w_last_pre;
    assign w_cpu_elig  = r_cpu_req && !r_cpu_busy;
    assign w_cpu_first = w_cpu_elig && (r_vid_run == 2'(MAX_VID_RUN));
    assign w_vid_gnt   = w_arb && r_vid_pend && !w_cpu_first;
    assign w_cpu_gnt   = w_arb && w_cpu_elig && !w_vid_gnt;
    assign w_gnt_addr  = w_vid_gnt ? r_vid_addr : i_CPU_ADDR;

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_state     <= S_IDLE;
            r_pre_cnt   <= '0;
            r_vid_pend  <= 1'b0;
            r_vid_addr  <= '0;
            r_cpu_req   <= 1'b0;
            r_cpu_busy  <= 1'b0;
            r_vid_run   <= '0;
            r_cur_cpu   <= 1'b0;
            r_cur_wr    <= 1'b0;
            r_cur_addr  <= '0;
            r_cur_din   <= '0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_vid_data  <= '0;
            r_cpu_dout  <= '0;
            r_vid_valid <= 1'b0;
            r_vid_miss  <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_ras_n     <= 1'b1;
            r_cas_n     <= 1'b1;
            r_wr_n      <= 1'b1;
            r_rd_n      <= 1'b1;
        end else begin
            r_vid_valid <= 1'b0;
            r_vid_miss  <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_req   <= i_CPU_REQ;

            // A pulse landing in the grant cycle becomes a fresh pending request
            if (i_VID_REQ) begin
                r_vid_pend <= 1'b1;
                r_vid_addr <= i_VID_ADDR;
                if (r_vid_pend && !w_vid_gnt) begin
                    r_vid_miss <= 1'b1;
                end
            end else if (w_vid_gnt) begin
                r_vid_pend <= 1'b0;
            end

            if (w_cpu_gnt) begin
                r_cpu_busy <= 1'b1;
            end else if (r_cpu_ack) begin
                r_cpu_busy <= 1'b0;
            end

            if (w_arb) begin
                if (!w_cpu_elig || w_cpu_gnt) begin
                    r_vid_run <= '0;
                end else if (w_vid_gnt && (r_vid_run != 2'd3)) begin
                    r_vid_run <= r_vid_run + 2'd1;
                end
            end

            if ((r_state == S_PRE) && (r_pre_cnt == '0)) begin
                if (r_cur_cpu) begin
                    r_cpu_dout <= i_RAM_DOUT;
                    r_cpu_ack  <= 1'b1;
                end else begin
                    r_vid_data  <= i_RAM_DOUT;
                    r_vid_valid <= 1'b1;
                end
            end

            case (r_state)
                S_ROW: begin
                    r_state    <= S_COL;
                    r_cas_n    <= 1'b0;
                    r_ram_addr <= {1'b0, r_cur_addr[13:8], 1'b0};
                end
                S_COL: begin
                    r_state <= S_ACC;
                    if (r_cur_wr) begin
                        r_wr_n    <= 1'b0;
                        r_ram_din <= r_cur_din;
                    end else begin
                        r_rd_n <= 1'b0;
                    end
                end
                S_ACC: begin
                    r_state    <= S_PRE;
                    r_pre_cnt  <= '0;
                    r_ras_n    <= 1'b1;
                    r_cas_n    <= 1'b1;
                    r_wr_n     <= 1'b1;
                    r_rd_n     <= 1'b1;
                    r_ram_addr <= '0;
                end
                S_IDLE, S_PRE: begin
                    if (!w_arb) begin
                        r_pre_cnt <= r_pre_cnt + PCW'(1);
                    end else if (w_vid_gnt || w_cpu_gnt) begin
                        r_state    <= S_ROW;
                        r_ras_n    <= 1'b0;
                        r_ram_addr <= w_gnt_addr[7:0];
                        r_cur_cpu  <= w_cpu_gnt;
                        r_cur_wr   <= w_cpu_gnt && i_CPU_WR;
                        r_cur_addr <= w_gnt_addr;
                        if (w_cpu_gnt) begin
                            r_cur_din <= i_CPU_DIN;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_VID_DATA  = r_vid_data;
    assign o_VID_VALID = r_vid_valid;
    assign o_VID_MISS  = r_vid_miss;
    assign o_CPU_DOUT  = r_cpu_dout;
    assign o_CPU_ACK   = r_cpu_ack;
    assign o_RAM_ADDR  = r_ram_addr;
    assign o_RAM_DIN   = r_ram_din;
    assign o_RAS_n     = r_ras_n;
    assign o_CAS_n     = r_cas_n;
    assign o_WR_n      = r_wr_n;
    assign o_RD_n      = r_rd_n;

endmodule

// File: tb/tb_charram_dram_ctrl.sv
// Directed bench for charram_dram_ctrl with a behavioural 4416 DRAM model.
module tb_charram_dram_ctrl;
    logic        clk;
    logic        rst_n;
    logic        vid_req;
    logic [13:0] vid_addr;
    logic [3:0]  o_VID_DATA;
    logic        o_VID_VALID;
    logic        o_VID_MISS;
    logic        cpu_req;
    logic        cpu_wr;
    logic [13:0] cpu_addr;
    logic [3:0]  cpu_din;
    logic [3:0]  o_CPU_DOUT;
    logic        o_CPU_ACK;
    logic [7:0]  o_RAM_ADDR;
    logic [3:0]  o_RAM_DIN;
    logic [3:0]  ram_dout;
    logic        o_RAS_n;
    logic        o_CAS_n;
    logic        o_WR_n;
    logic        o_RD_n;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    charram_dram_ctrl dut (
        .i_MCLK(clk), .i_RST_n(rst_n),
        .i_VID_REQ(vid_req), .i_VID_ADDR(vid_addr),
        .o_VID_DATA(o_VID_DATA), .o_VID_VALID(o_VID_VALID), .o_VID_MISS(o_VID_MISS),
        .i_CPU_REQ(cpu_req), .i_CPU_WR(cpu_wr), .i_CPU_ADDR(cpu_addr), .i_CPU_DIN(cpu_din),
        .o_CPU_DOUT(o_CPU_DOUT), .o_CPU_ACK(o_CPU_ACK),
        .o_RAM_ADDR(o_RAM_ADDR), .o_RAM_DIN(o_RAM_DIN), .i_RAM_DOUT(ram_dout),
        .o_RAS_n(o_RAS_n), .o_CAS_n(o_CAS_n), .o_WR_n(o_WR_n), .o_RD_n(o_RD_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DRAM model: row latched while RAS low / CAS high; access when RD_n or WR_n low
    logic [3:0] mem [16384];
    logic [7:0] m_row = 8'h00;
    always @(posedge clk) begin
        if (!o_RAS_n && o_CAS_n) m_row <= o_RAM_ADDR;
        if (!o_RAS_n && !o_CAS_n && !o_WR_n) mem[{o_RAM_ADDR[6:1], m_row}] <= o_RAM_DIN;
        if (!o_RAS_n && !o_CAS_n && !o_RD_n) ram_dout <= mem[{o_RAM_ADDR[6:1], m_row}];
    end

    // Event log sampled mid-cycle
    int         row_q[$];
    logic [7:0] rowa_q[$];
    logic [7:0] cola_q[$];
    int         ack_q[$];
    int         val_q[$];
    logic [3:0] vdat_q[$];
    int         wr_cnt;
    int         rd_cnt;
    int         miss_cnt;
    always @(negedge clk) begin
        if (!o_RAS_n && o_CAS_n) begin row_q.push_back(cyc); rowa_q.push_back(o_RAM_ADDR); end
        if (!o_RAS_n && !o_CAS_n && o_WR_n && o_RD_n) cola_q.push_back(o_RAM_ADDR);
        if (!o_WR_n) wr_cnt++;
        if (!o_RD_n) rd_cnt++;
        if (o_CPU_ACK) ack_q.push_back(cyc);
        if (o_VID_VALID) begin val_q.push_back(cyc); vdat_q.push_back(o_VID_DATA); end
        if (o_VID_MISS) miss_cnt++;
    end

    task automatic clear_mon();
        row_q.delete(); rowa_q.delete(); cola_q.delete();
        ack_q.delete(); val_q.delete(); vdat_q.delete();
        wr_cnt = 0; rd_cnt = 0; miss_cnt = 0;
    endtask

    task automatic cpu_access(input logic wr, input logic [13:0] addr, input logic [3:0] din,
                              output int c, output logic [3:0] dout, output bit got);
        @(negedge clk);
        c = cyc; cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_din = din;
        got = 1'b0; dout = 4'h0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_CPU_ACK) begin got = 1'b1; dout = o_CPU_DOUT; cpu_req = 1'b0; break; end
        end
        cpu_req = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vid_req = 0; vid_addr = '0; cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_din = '0;
        repeat (3) @(negedge clk);
        checks++; if ({o_RAS_n, o_CAS_n, o_WR_n, o_RD_n} !== 4'hF) $display("FAIL reset_strobes got %b expected 1111", {o_RAS_n, o_CAS_n, o_WR_n, o_RD_n}); else passes++;
        checks++; if (o_RAM_ADDR !== 8'h00) $display("FAIL reset_ram_addr got %h expected 00", o_RAM_ADDR); else passes++;
        checks++; if ({o_RAM_DIN, o_VID_DATA, o_CPU_DOUT} !== 12'h000) $display("FAIL reset_data got %h expected 000", {o_RAM_DIN, o_VID_DATA, o_CPU_DOUT}); else passes++;
        checks++; if ({o_VID_VALID, o_VID_MISS, o_CPU_ACK} !== 3'b000) $display("FAIL reset_pulses got %b expected 000", {o_VID_VALID, o_VID_MISS, o_CPU_ACK}); else passes++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cpu_write();
        int c; logic [3:0] d; bit got;
        clear_mon();
        cpu_access(1'b1, 14'h2A5C, 4'h9, c, d, got);
        checks++; if (!got) $display("FAIL wr_ack_timeout got none expected ack"); else passes++;
        checks++; if (row_q.size() != 1 || row_q[0] != c + 2) $display("FAIL wr_row_cycle got n=%0d c0=%0d expected 1 at %0d", row_q.size(), (row_q.size() > 0) ? row_q[0] - c : -1, 2); else passes++;
        checks++; if (rowa_q.size() < 1 || rowa_q[0] !== 8'h5C) $display("FAIL wr_row_addr got %h expected 5c", (rowa_q.size() > 0) ? rowa_q[0] : 8'hxx); else passes++;
        checks++; if (cola_q.size() < 1 || cola_q[0] !== 8'h54) $display("FAIL wr_col_addr got %h expected 54", (cola_q.size() > 0) ? cola_q[0] : 8'hxx); else passes++;
        checks++; if (wr_cnt != 1 || rd_cnt != 0) $display("FAIL wr_strobes got wr=%0d rd=%0d expected 1 0", wr_cnt, rd_cnt); else passes++;
        checks++; if (ack_q.size() != 1 || ack_q[0] != c + 6) $display("FAIL wr_ack_cycle got n=%0d expected 1 at offset 6", ack_q.size()); else passes++;
        checks++; if (mem[14'h2A5C] !== 4'h9) $display("FAIL wr_mem got %h expected 9", mem[14'h2A5C]); else passes++;
    endtask

    task automatic test_cpu_read();
        int c; logic [3:0] d; bit got;
        clear_mon();
        cpu_access(1'b0, 14'h2A5C, 4'h0, c, d, got);
        checks++; if (!got || d !== 4'h9) $display("FAIL rd_dout got %h expected 9", d); else passes++;
        checks++; if (rd_cnt != 1 || wr_cnt != 0) $display("FAIL rd_strobes got rd=%0d wr=%0d expected 1 0", rd_cnt, wr_cnt); else passes++;
        checks++; if (ack_q.size() != 1 || ack_q[0] != c + 6) $display("FAIL rd_ack_cycle got n=%0d expected 1 at offset 6", ack_q.size()); else passes++;
    endtask

    task automatic preload();
        int c; logic [3:0] d; bit got;
        cpu_access(1'b1, 14'h0123, 4'h6, c, d, got);
        cpu_access(1'b1, 14'h0111, 4'hC, c, d, got);
        cpu_access(1'b1, 14'h0222, 4'h5, c, d, got);
        cpu_access(1'b1, 14'h0333, 4'h1, c, d, got);
    endtask

    task automatic test_same_cycle();
        int c; logic [3:0] d;
        clear_mon();
        @(negedge clk);
        c = cyc; d = 4'h0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h2A5C; vid_addr = 14'h0123;
        for (int i = 0; i < 30; i++) begin
            if (o_CPU_ACK) begin d = o_CPU_DOUT; cpu_req = 1'b0; end
            vid_req = (i == 0);
            @(negedge clk);
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        checks++; if (row_q.size() != 2) $display("FAIL same_row_count got %0d expected 2", row_q.size()); else passes++;
        checks++; if (row_q.size() < 2 || row_q[0] != c + 2 || row_q[1] != c + 6) $display("FAIL same_row_cycles got %0d,%0d expected 2,6", (row_q.size() > 0) ? row_q[0] - c : -1, (row_q.size() > 1) ? row_q[1] - c : -1); else passes++;
        checks++; if (rowa_q.size() < 2 || rowa_q[0] !== 8'h23 || rowa_q[1] !== 8'h5C) $display("FAIL same_row_addrs got n=%0d expected 23 then 5c", rowa_q.size()); else passes++;
        checks++; if (val_q.size() != 1 || val_q[0] != c + 6 || vdat_q[0] !== 4'h6) $display("FAIL same_valid got n=%0d expected one pulse at 6 with 6", val_q.size()); else passes++;
        checks++; if (ack_q.size() != 1 || ack_q[0] != c + 10) $display("FAIL same_ack got n=%0d expected one pulse at 10", ack_q.size()); else passes++;
        checks++; if (d !== 4'h9) $display("FAIL same_dout got %h expected 9", d); else passes++;
    endtask

    task automatic test_vid_run();
        int c; int nv;
        clear_mon();
        @(negedge clk);
        c = cyc; nv = 0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h2A5C; vid_addr = 14'h0123;
        for (int i = 0; i < 40; i++) begin
            if (o_CPU_ACK) cpu_req = 1'b0;
            vid_req = (i < 16) && (i % 4 == 0);
            @(negedge clk);
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        foreach (val_q[k]) if (ack_q.size() > 0 && val_q[k] < ack_q[0]) nv++;
        checks++; if (ack_q.size() != 1 || ack_q[0] != c + 18) $display("FAIL run_ack got n=%0d expected one at offset 18", ack_q.size()); else passes++;
        checks++; if (nv != 3) $display("FAIL run_vid_before_cpu got %0d expected 3", nv); else passes++;
        checks++; if (row_q.size() < 4 || row_q[3] != c + 14 || rowa_q[3] !== 8'h5C) $display("FAIL run_cpu_row got n=%0d expected cpu row at offset 14", row_q.size()); else passes++;
        checks++; if (miss_cnt != 0 || val_q.size() != 4) $display("FAIL run_vid_total got miss=%0d valid=%0d expected 0 4", miss_cnt, val_q.size()); else passes++;
    endtask

    task automatic test_miss();
        int c;
        clear_mon();
        @(negedge clk);
        c = cyc;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h2A5C;
        for (int i = 0; i < 30; i++) begin
            if (o_CPU_ACK) cpu_req = 1'b0;
            vid_req = (i == 2) || (i == 3);
            vid_addr = (i == 2) ? 14'h0111 : 14'h0222;
            @(negedge clk);
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        checks++; if (miss_cnt != 1) $display("FAIL miss_count got %0d expected 1", miss_cnt); else passes++;
        checks++; if (val_q.size() != 1 || vdat_q[0] !== 4'h5) $display("FAIL miss_fetch got n=%0d expected one valid with 5", val_q.size()); else passes++;
        checks++; if (val_q.size() < 1 || val_q[0] != c + 10) $display("FAIL miss_valid_cycle got n=%0d expected offset 10", val_q.size()); else passes++;
        checks++; if (rowa_q.size() != 2 || rowa_q[1] !== 8'h22) $display("FAIL miss_row_addr got n=%0d expected second row 22", rowa_q.size()); else passes++;
        checks++; if (ack_q.size() != 1 || ack_q[0] != c + 6) $display("FAIL miss_cpu_ack got n=%0d expected one at offset 6", ack_q.size()); else passes++;
    endtask

    task automatic test_reset_mid();
        int c; logic [3:0] d; bit got;
        clear_mon();
        @(negedge clk);
        c = cyc;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 14'h0333; cpu_din = 4'h7;
        repeat (4) @(negedge clk);
        checks++; if (o_WR_n !== 1'b0) $display("FAIL rstmid_in_acc got wr_n=%b expected 0", o_WR_n); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if ({o_RAS_n, o_CAS_n, o_WR_n, o_RD_n} !== 4'hF) $display("FAIL rstmid_strobes got %b expected 1111", {o_RAS_n, o_CAS_n, o_WR_n, o_RD_n}); else passes++;
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (ack_q.size() != 0 || val_q.size() != 0) $display("FAIL rstmid_no_ack got ack=%0d valid=%0d expected 0 0", ack_q.size(), val_q.size()); else passes++;
        checks++; if (mem[14'h0333] !== 4'h1) $display("FAIL rstmid_mem got %h expected 1", mem[14'h0333]); else passes++;
        clear_mon();
        cpu_access(1'b1, 14'h0333, 4'h7, c, d, got);
        checks++; if (!got || ack_q.size() != 1 || ack_q[0] != c + 6) $display("FAIL rstmid_recover_ack got n=%0d expected one at offset 6", ack_q.size()); else passes++;
        checks++; if (mem[14'h0333] !== 4'h7) $display("FAIL rstmid_recover_mem got %h expected 7", mem[14'h0333]); else passes++;
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        preload();
        test_same_cycle();
        test_vid_run();
        test_vid_run();
        test_miss();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
